// File: rtl/pipe_stage_ctrl.sv
// Stage sequencer for an N-stage in-order pipeline: per-stage clear/enable/valid,
// a debug run/halt/step FSM, whole-pipe freeze on ext_busy and a retired-instruction counter.
module pipe_stage_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int STALL_STAGE = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  debug_en_i,
  input  logic                  debug_step_i,
  input  logic                  stall_req_i,
  input  logic                  flush_req_i,
  input  logic                  ext_busy_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic                  halted_o,
  output logic [CNT_W-1:0]      retire_cnt_o
);

  if ((STALL_STAGE + 1 >= NUM_STAGES) || (FLUSH_DEPTH >= NUM_STAGES) || (FLUSH_DEPTH < 1))
  begin : g_bad_params
    $error("pipe_stage_ctrl: illegal STALL_STAGE/FLUSH_DEPTH for NUM_STAGES");
  end

  typedef enum logic [1:0] {RUN, HALT, STEP} state_e;

  state_e                 state_q;
  logic                   halted_q;
  logic                   sync1_q, sync2_q, prev_q;
  logic                   step_pulse;
  logic                   adv;
  logic [NUM_STAGES-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]       retire_q, retire_d;

  assign step_pulse = sync2_q & ~prev_q;
  assign adv        = ~rst_i & ~ext_busy_i & ((state_q == RUN) | (state_q == STEP));

  always_comb begin
    stage_en_o  = '0;
    stage_rst_o = '0;
    valid_d     = valid_q;
    retire_d    = retire_q;
    if (rst_i) begin
      stage_rst_o = '1;
    end else if (adv) begin
      stage_en_o = '1;
      valid_d    = {valid_q[NUM_STAGES-2:0], 1'b1};
      if (valid_q[NUM_STAGES-1]) retire_d = retire_q + CNT_W'(1);
      if (stall_req_i) begin
        // Hold the front of the pipe and inject a bubble right behind it.
        for (int i = 0; i <= STALL_STAGE; i++) begin
          stage_en_o[i] = 1'b0;
          valid_d[i]    = valid_q[i];
        end
        stage_rst_o[STALL_STAGE+1] = 1'b1;
        valid_d[STALL_STAGE+1]     = 1'b0;
      end else if (flush_req_i) begin
        for (int i = 1; i <= FLUSH_DEPTH; i++) begin
          stage_rst_o[i] = 1'b1;
          valid_d[i]     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= debug_step_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      retire_q <= '0;
    end else begin
      valid_q  <= valid_d;
      retire_q <= retire_d;
    end
  end

  // A pending step sits in STEP until the pipe actually advances once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (debug_en_i) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (!debug_en_i) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end else if (step_pulse) begin
            state_q  <= STEP;
            halted_q <= 1'b0;
          end
        end
        STEP: begin
          if (adv) begin
            state_q  <= debug_en_i ? HALT : RUN;
            halted_q <= debug_en_i;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign stage_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign retire_cnt_o  = retire_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed scenarios followed by random traffic, all
// compared every cycle against a behavioural model of the stage sequencing rules.
module tb_pipe_stage_ctrl;
  localparam int N  = 5;
  localparam int S  = 1;
  localparam int F  = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          debug_en = 1'b0, debug_step = 1'b0;
  logic          stall = 1'b0, flush = 1'b0, busy = 1'b0;
  logic [N-1:0]  stage_rst, stage_en, stage_valid;
  logic          halted;
  logic [CW-1:0] retire_cnt;

  pipe_stage_ctrl #(.NUM_STAGES(N), .STALL_STAGE(S), .FLUSH_DEPTH(F), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .debug_en_i(debug_en), .debug_step_i(debug_step),
    .stall_req_i(stall), .flush_req_i(flush), .ext_busy_i(busy),
    .stage_rst_o(stage_rst), .stage_en_o(stage_en), .stage_valid_o(stage_valid),
    .halted_o(halted), .retire_cnt_o(retire_cnt)
  );

  always #5 clk = ~clk;

  int            total = 0, bad = 0, advcnt = 0;
  bit            init = 0;
  logic [N-1:0]  mvalid = '0;
  int            mmode = 0;          // 0 run, 1 halted, 2 step pending
  logic [CW-1:0] mcnt = '0;
  logic [2:0]    smp = '0;           // pin samples at past edges, [0] newest

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [N-1:0] xen, xrst, nv, low, allm;
    bit           adv, pulse;
    allm = N'((1 << N) - 1);
    low  = N'((1 << (S + 1)) - 1);
    @(negedge clk);
    adv = !rst && !busy && (mmode != 1);
    if (rst) begin
      xen = '0; xrst = allm;
    end else if (!adv) begin
      xen = '0; xrst = '0;
    end else if (stall) begin
      xen = allm & ~low; xrst = N'(1 << (S + 1));
    end else if (flush) begin
      xen = allm; xrst = N'(((1 << F) - 1) << 1);
    end else begin
      xen = allm; xrst = '0;
    end
    chk("stage_en", 32'(stage_en), 32'(xen));
    chk("stage_rst", 32'(stage_rst), 32'(xrst));
    if (init) begin
      chk("stage_valid", 32'(stage_valid), 32'(mvalid));
      chk("halted", 32'(halted), 32'(mmode == 1));
      chk("retire_cnt", 32'(retire_cnt), 32'(mcnt));
    end
    if (stage_en[N-1]) advcnt++;
    @(posedge clk);
    pulse = smp[1] & ~smp[2];
    if (rst) begin
      mvalid = '0; mmode = 0; mcnt = '0; smp = '0; init = 1;
    end else begin
      if (adv) begin
        if (mvalid[N-1]) mcnt = mcnt + 1'b1;
        nv = N'({mvalid, 1'b1});
        if (stall) nv = (nv & ~low & ~N'(1 << (S + 1))) | (mvalid & low);
        else if (flush) nv = nv & ~N'(((1 << F) - 1) << 1);
        mvalid = nv;
      end
      case (mmode)
        0: if (debug_en) mmode = 1;
        1: if (!debug_en) mmode = 0; else if (pulse) mmode = 2;
        default: if (adv) mmode = debug_en ? 1 : 0;
      endcase
      smp = {smp[1:0], debug_step};
    end
    #1;
  endtask

  initial begin
    // Reset and fill
    cyc(); cyc();
    rst = 0;
    repeat (5) cyc();
    chk("fill_valid", 32'(stage_valid), 32'h1f);

    // One-cycle stall on a full pipe
    stall = 1; #1;
    chk("stall_en", 32'(stage_en), 32'h1c);
    chk("stall_rst", 32'(stage_rst), 32'h04);
    cyc(); stall = 0;
    chk("stall_bubble", 32'(stage_valid), 32'h1b);

    // Flush, then stall+flush together
    flush = 1; #1;
    chk("flush_en", 32'(stage_en), 32'h1f);
    chk("flush_rst", 32'(stage_rst), 32'h02);
    cyc(); flush = 0;
    chk("flush_v1", 32'(stage_valid[1]), 32'h0);
    stall = 1; flush = 1; #1;
    chk("stallflush_en", 32'(stage_en), 32'h1c);
    chk("stallflush_rst", 32'(stage_rst), 32'h04);
    cyc(); stall = 0; flush = 0;
    repeat (3) cyc();

    // Debug halt and a long step press
    debug_en = 1; cyc(); cyc();
    chk("halted_on", 32'(halted), 32'h1);
    advcnt = 0; debug_step = 1;
    repeat (10) cyc();
    debug_step = 0;
    repeat (4) cyc();
    chk("one_step", 32'(advcnt), 32'd1);

    // Step held off by ext_busy
    advcnt = 0; debug_step = 1;
    cyc(); cyc();
    busy = 1;
    repeat (4) cyc();
    chk("busy_no_adv", 32'(advcnt), 32'd0);
    busy = 0; debug_step = 0;
    cyc();
    chk("step_after_busy", 32'(advcnt), 32'd1);
    repeat (3) cyc();
    chk("step_once", 32'(advcnt), 32'd1);

    // ext_busy while running
    debug_en = 0; cyc(); cyc();
    busy = 1; #1;
    chk("busy_run_en", 32'(stage_en), 32'h0);
    repeat (3) cyc();
    busy = 0;

    // Counter wrap: 17 retirements in a 4-bit counter
    rst = 1; cyc(); rst = 0;
    repeat (22) cyc();
    chk("retire_wrap", 32'(retire_cnt), 32'd1);

    // Reset in the middle of a stall
    stall = 1; cyc();
    rst = 1; #1;
    chk("midrst_rst", 32'(stage_rst), 32'h1f);
    chk("midrst_en", 32'(stage_en), 32'h0);
    cyc(); rst = 0; stall = 0;
    chk("midrst_valid", 32'(stage_valid), 32'h0);
    chk("midrst_cnt", 32'(retire_cnt), 32'h0);

    // Random traffic
    repeat (400) begin
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 3) == 0);
      busy  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) debug_en = ~debug_en;
      if ($urandom_range(0, 5) == 0) debug_step = ~debug_step;
      cyc();
    end
    rst = 0; stall = 0; flush = 0; busy = 0; debug_en = 0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
